// File: rtl/enemy_hit_judge.sv
// enemy_hit_judge
//   Collision arbiter in front of the enemy plane stage. Counts per-frame overlap
//   pixels between the enemy and the player bullet / player plane, decides at each
//   frame boundary whether a hit occurred, then drives the enemy's boom/revive
//   request levels for a fixed number of clk_move rising edges.
//
// Ports
//   clk               system/pixel clock, rising edge
//   rst_n             asynchronous active-low reset
//   clk_move          slow movement clock, synchronous to clk (rising edge = tick)
//   frame_start       one-clk pulse on the first pixel of a frame
//   enemy_en          enemy pixel opaque at current scan position
//   bullet_en         bullet pixel opaque at current scan position
//   player_en         player pixel opaque at current scan position
//   enemyplane_exist  enemy alive flag from the enemy stage
//   boom              explosion request level
//   revive            respawn request level
//   bullet_hit        one-clk pulse, bullet consumed
//   player_hit        one-clk pulse, player collided with enemy
//   kills             saturating count of bullet kills since reset
module enemy_hit_judge #(
    parameter int unsigned HIT_MIN_PIXELS = 4,
    parameter int unsigned BOOM_TICKS     = 255,
    parameter int unsigned REVIVE_TICKS   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_move,
    input  logic       frame_start,
    input  logic       enemy_en,
    input  logic       bullet_en,
    input  logic       player_en,
    input  logic       enemyplane_exist,
    output logic       boom,
    output logic       revive,
    output logic       bullet_hit,
    output logic       player_hit,
    output logic [7:0] kills
);

    typedef enum logic [1:0] {StIdle, StBoom, StRevive} state_e;

    localparam logic [11:0] HitMin     = 12'(HIT_MIN_PIXELS);
    localparam logic [7:0]  BoomLast   = 8'(BOOM_TICKS - 1);
    localparam logic [7:0]  ReviveLast = 8'(REVIVE_TICKS - 1);

    state_e      state_q;
    logic        clk_move_q;
    logic        tick_arm_q;
    logic        frame_arm_q;
    logic [11:0] bcnt_q;
    logic [11:0] pcnt_q;
    logic [7:0]  tcnt_q;
    logic        boom_q;
    logic        revive_q;
    logic        bullet_hit_q;
    logic        player_hit_q;
    logic [7:0]  kills_q;

    logic move_tick;
    logic b_ovl;
    logic p_ovl;
    logic b_hit;
    logic p_hit;

    // tick_arm_q masks the first cycle after reset so a clk_move level held
    // high across reset is not mistaken for a rising edge.
    assign move_tick = clk_move & ~clk_move_q & tick_arm_q;
    assign b_ovl     = bullet_en & enemy_en;
    assign p_ovl     = player_en & enemy_en;

    // frame_arm_q: the counts seen at the first frame_start after reset cover
    // only a partial frame, so no hit is judged until one full frame has passed.
    assign b_hit = frame_arm_q & enemyplane_exist & (bcnt_q >= HitMin);
    assign p_hit = frame_arm_q & enemyplane_exist & (pcnt_q >= HitMin);

    assign boom       = boom_q;
    assign revive     = revive_q;
    assign bullet_hit = bullet_hit_q;
    assign player_hit = player_hit_q;
    assign kills      = kills_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_move_q  <= 1'b0;
            tick_arm_q  <= 1'b0;
            frame_arm_q <= 1'b0;
        end else begin
            clk_move_q <= clk_move;
            tick_arm_q <= 1'b1;
            if (frame_start) begin
                frame_arm_q <= 1'b1;
            end
        end
    end

    // Overlap counters: count only while idle; the frame_start pixel starts
    // the new frame's count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q <= '0;
            pcnt_q <= '0;
        end else if (state_q != StIdle) begin
            bcnt_q <= '0;
            pcnt_q <= '0;
        end else if (frame_start) begin
            bcnt_q <= {11'd0, b_ovl};
            pcnt_q <= {11'd0, p_ovl};
        end else begin
            if (b_ovl && (bcnt_q != 12'hFFF)) begin
                bcnt_q <= bcnt_q + 12'd1;
            end
            if (p_ovl && (pcnt_q != 12'hFFF)) begin
                pcnt_q <= pcnt_q + 12'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            tcnt_q       <= '0;
            boom_q       <= 1'b0;
            revive_q     <= 1'b0;
            bullet_hit_q <= 1'b0;
            player_hit_q <= 1'b0;
            kills_q      <= '0;
        end else begin
            bullet_hit_q <= 1'b0;
            player_hit_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (frame_start && (b_hit || p_hit)) begin
                        bullet_hit_q <= b_hit;
                        player_hit_q <= p_hit;
                        if (b_hit && (kills_q != 8'hFF)) begin
                            kills_q <= kills_q + 8'd1;
                        end
                        tcnt_q  <= '0;
                        boom_q  <= 1'b1;
                        state_q <= StBoom;
                    end
                end
                StBoom: begin
                    if (move_tick) begin
                        if (tcnt_q == BoomLast) begin
                            tcnt_q   <= '0;
                            boom_q   <= 1'b0;
                            revive_q <= 1'b1;
                            state_q  <= StRevive;
                        end else begin
                            tcnt_q <= tcnt_q + 8'd1;
                        end
                    end
                end
                StRevive: begin
                    if (move_tick) begin
                        if (tcnt_q == ReviveLast) begin
                            tcnt_q   <= '0;
                            revive_q <= 1'b0;
                            state_q  <= StIdle;
                        end else begin
                            tcnt_q <= tcnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    tcnt_q   <= '0;
                    boom_q   <= 1'b0;
                    revive_q <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enemy_hit_judge.sv
// Bench for enemy_hit_judge. Two instances share stimulus: dut (default
// parameters) and dut_s (BOOM_TICKS=1) used for the kills saturation run.
module tb_enemy_hit_judge;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_move = 1'b0;
    logic       frame_start = 1'b0;
    logic       enemy_en = 1'b0;
    logic       bullet_en = 1'b0;
    logic       player_en = 1'b0;
    logic       exist = 1'b1;

    logic       boom, revive, bh, ph;
    logic [7:0] kills;
    logic       boom_s, revive_s, bh_s, ph_s;
    logic [7:0] kills_s;

    typedef struct packed {
        logic       bh;
        logic       ph;
        logic [7:0] kills;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int checks = 0;
    int failures = 0;
    int exp_kills = 0;
    int exp_bh_total = 0;
    int bh_seen = 0;

    always #5 clk = ~clk;

    enemy_hit_judge dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .clk_move         (clk_move),
        .frame_start      (frame_start),
        .enemy_en         (enemy_en),
        .bullet_en        (bullet_en),
        .player_en        (player_en),
        .enemyplane_exist (exist),
        .boom             (boom),
        .revive           (revive),
        .bullet_hit       (bh),
        .player_hit       (ph),
        .kills            (kills)
    );

    enemy_hit_judge #(
        .HIT_MIN_PIXELS (4),
        .BOOM_TICKS     (1),
        .REVIVE_TICKS   (2)
    ) dut_s (
        .clk              (clk),
        .rst_n            (rst_n),
        .clk_move         (clk_move),
        .frame_start      (frame_start),
        .enemy_en         (enemy_en),
        .bullet_en        (bullet_en),
        .player_en        (player_en),
        .enemyplane_exist (exist),
        .boom             (boom_s),
        .revive           (revive_s),
        .bullet_hit       (bh_s),
        .player_hit       (ph_s),
        .kills            (kills_s)
    );

    // Counts every cycle bullet_hit is high, so a stretched or stray pulse shows up.
    always @(negedge clk) begin
        if (bh === 1'b1) bh_seen++;
    end

    // Inputs change right after a falling edge; outputs are read on falling edges.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic tick();
        clk_move = 1'b1;
        cyc();
        clk_move = 1'b0;
        cyc();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Two bullet/player-only pixels (no enemy, must not count), then overlaps.
    task automatic pixels(input int nb, input int np);
        int n;
        n = (nb > np) ? nb : np;
        bullet_en = 1'b1;
        player_en = 1'b1;
        cyc();
        cyc();
        for (int i = 0; i < n; i++) begin
            enemy_en  = 1'b1;
            bullet_en = (i < nb);
            player_en = (i < np);
            cyc();
        end
        enemy_en  = 1'b0;
        bullet_en = 1'b0;
        player_en = 1'b0;
        cyc();
    endtask

    task automatic push(input logic b, input logic p, input int k);
        exp_t x;
        x.bh = b;
        x.ph = p;
        x.kills = 8'(k);
        sb.push_back(x);
        if (b) exp_bh_total++;
    endtask

    // Pulse frame_start; on return the outputs reflect that edge.
    task automatic fs();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        checks++;
        if ({boom, revive, bh, ph, kills} !== 12'd0) begin
            failures++;
            $display("FAIL reset_dut: got %b expected 0", {boom, revive, bh, ph, kills});
        end
        checks++;
        if ({boom_s, revive_s, bh_s, ph_s, kills_s} !== 12'd0) begin
            failures++;
            $display("FAIL reset_dut_s: got %b expected 0",
                     {boom_s, revive_s, bh_s, ph_s, kills_s});
        end
        rst_n = 1'b1;
        cyc();
        fs();
        cyc();
    endtask

    task automatic test_threshold();
        pixels(3, 3);
        push(1'b0, 1'b0, exp_kills);
        fs();
        e = sb.pop_front();
        checks++;
        if ({bh, ph, kills} !== {e.bh, e.ph, e.kills}) begin
            failures++;
            $display("FAIL threshold_3px: got bh=%b ph=%b kills=%0d expected bh=%b ph=%b kills=%0d",
                     bh, ph, kills, e.bh, e.ph, e.kills);
        end
        cyc();
        checks++;
        if (boom !== 1'b0) begin
            failures++;
            $display("FAIL threshold_boom: got %b expected 0", boom);
        end
    endtask

    task automatic test_bullet_kill();
        pixels(4, 0);
        exp_kills++;
        push(1'b1, 1'b0, exp_kills);
        fs();
        e = sb.pop_front();
        checks++;
        if ({bh, ph, kills} !== {e.bh, e.ph, e.kills}) begin
            failures++;
            $display("FAIL kill_pulse: got bh=%b ph=%b kills=%0d expected bh=%b ph=%b kills=%0d",
                     bh, ph, kills, e.bh, e.ph, e.kills);
        end
        checks++;
        if ({boom, revive} !== 2'b10) begin
            failures++;
            $display("FAIL kill_boom_rise: got boom/revive=%b expected 10", {boom, revive});
        end
        cyc();
        checks++;
        if ({bh, boom} !== 2'b01) begin
            failures++;
            $display("FAIL kill_pulse_width: got bh/boom=%b expected 01", {bh, boom});
        end
        ticks(254);
        checks++;
        if ({boom, revive} !== 2'b10) begin
            failures++;
            $display("FAIL kill_254_ticks: got boom/revive=%b expected 10", {boom, revive});
        end
        tick();
        checks++;
        if ({boom, revive} !== 2'b01) begin
            failures++;
            $display("FAIL kill_255_ticks: got boom/revive=%b expected 01", {boom, revive});
        end
        tick();
        checks++;
        if ({boom, revive} !== 2'b01) begin
            failures++;
            $display("FAIL kill_revive_1: got boom/revive=%b expected 01", {boom, revive});
        end
        tick();
        checks++;
        if ({boom, revive} !== 2'b00) begin
            failures++;
            $display("FAIL kill_revive_2: got boom/revive=%b expected 00", {boom, revive});
        end
    endtask

    // Both overlaps in one frame; a move tick coincides with the deciding frame_start.
    task automatic test_both();
        pixels(5, 6);
        exp_kills++;
        push(1'b1, 1'b1, exp_kills);
        clk_move = 1'b1;
        fs();
        clk_move = 1'b0;
        e = sb.pop_front();
        checks++;
        if ({bh, ph, kills} !== {e.bh, e.ph, e.kills}) begin
            failures++;
            $display("FAIL both_pulse: got bh=%b ph=%b kills=%0d expected bh=%b ph=%b kills=%0d",
                     bh, ph, kills, e.bh, e.ph, e.kills);
        end
        cyc();
        ticks(254);
        checks++;
        if ({boom, revive} !== 2'b10) begin
            failures++;
            $display("FAIL both_coincident_tick: got boom/revive=%b expected 10", {boom, revive});
        end
        tick();
        checks++;
        if ({boom, revive} !== 2'b01) begin
            failures++;
            $display("FAIL both_to_revive: got boom/revive=%b expected 01", {boom, revive});
        end
        ticks(2);
        checks++;
        if ({boom, revive, kills} !== {2'b00, 8'(exp_kills)}) begin
            failures++;
            $display("FAIL both_end: got boom/revive=%b kills=%0d expected 00 kills=%0d",
                     {boom, revive}, kills, exp_kills);
        end
    endtask

    task automatic test_no_exist();
        exist = 1'b0;
        pixels(10, 10);
        push(1'b0, 1'b0, exp_kills);
        fs();
        exist = 1'b1;
        e = sb.pop_front();
        checks++;
        if ({bh, ph, kills, boom} !== {e.bh, e.ph, e.kills, 1'b0}) begin
            failures++;
            $display("FAIL no_exist: got bh=%b ph=%b kills=%0d boom=%b expected bh=0 ph=0 kills=%0d boom=0",
                     bh, ph, kills, boom, e.kills);
        end
        pixels(4, 0);
        exp_kills++;
        push(1'b1, 1'b0, exp_kills);
        fs();
        e = sb.pop_front();
        checks++;
        if ({bh, ph, kills} !== {e.bh, e.ph, e.kills}) begin
            failures++;
            $display("FAIL busy_entry: got bh=%b ph=%b kills=%0d expected bh=%b ph=%b kills=%0d",
                     bh, ph, kills, e.bh, e.ph, e.kills);
        end
        cyc();
        pixels(10, 10);
        push(1'b0, 1'b0, exp_kills);
        fs();
        e = sb.pop_front();
        checks++;
        if ({bh, ph, kills, boom} !== {e.bh, e.ph, e.kills, 1'b1}) begin
            failures++;
            $display("FAIL busy_boom_ignored: got bh=%b ph=%b kills=%0d boom=%b expected bh=0 ph=0 kills=%0d boom=1",
                     bh, ph, kills, boom, e.kills);
        end
        ticks(255);
        pixels(10, 10);
        ticks(2);
        push(1'b0, 1'b0, exp_kills);
        fs();
        e = sb.pop_front();
        checks++;
        if ({bh, ph, kills, boom} !== {e.bh, e.ph, e.kills, 1'b0}) begin
            failures++;
            $display("FAIL busy_revive_ignored: got bh=%b ph=%b kills=%0d boom=%b expected bh=0 ph=0 kills=%0d boom=0",
                     bh, ph, kills, boom, e.kills);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        pixels(4, 0);
        exp_kills++;
        push(1'b1, 1'b0, exp_kills);
        fs();
        e = sb.pop_front();
        checks++;
        if ({bh, ph, kills} !== {e.bh, e.ph, e.kills}) begin
            failures++;
            $display("FAIL rst_mid_entry: got bh=%b ph=%b kills=%0d expected bh=%b ph=%b kills=%0d",
                     bh, ph, kills, e.bh, e.ph, e.kills);
        end
        cyc();
        ticks(100);
        clk_move = 1'b1;
        cyc();
        #2;
        rst_n = 1'b0;
        exp_kills = 0;
        #1;
        checks++;
        if ({boom, revive, bh, ph, kills} !== 12'd0) begin
            failures++;
            $display("FAIL rst_mid_async: got %b expected 0", {boom, revive, bh, ph, kills});
        end
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
        checks++;
        if ({boom, revive, kills} !== 10'd0) begin
            failures++;
            $display("FAIL rst_mid_idle: got boom/revive=%b kills=%0d expected 00 kills=0",
                     {boom, revive}, kills);
        end
        clk_move = 1'b0;
        pixels(4, 0);
        push(1'b0, 1'b0, exp_kills);
        fs();
        e = sb.pop_front();
        checks++;
        if ({bh, ph, kills, boom} !== {e.bh, e.ph, e.kills, 1'b0}) begin
            failures++;
            $display("FAIL rst_mid_partial_frame: got bh=%b ph=%b kills=%0d boom=%b expected no hit",
                     bh, ph, kills, boom);
        end
        pixels(4, 0);
        exp_kills++;
        push(1'b1, 1'b0, exp_kills);
        fs();
        e = sb.pop_front();
        checks++;
        if ({bh, ph, kills} !== {e.bh, e.ph, e.kills}) begin
            failures++;
            $display("FAIL rst_mid_full_frame: got bh=%b ph=%b kills=%0d expected bh=%b ph=%b kills=%0d",
                     bh, ph, kills, e.bh, e.ph, e.kills);
        end
        cyc();
    endtask

    task automatic test_pulse_total();
        checks++;
        if (bh_seen !== exp_bh_total) begin
            failures++;
            $display("FAIL bullet_hit_cycles: got %0d expected %0d", bh_seen, exp_bh_total);
        end
    endtask

    task automatic test_saturation();
        int k;
        k = 0;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        fs();
        cyc();
        for (int i = 0; i < 256; i++) begin
            pixels(4, 0);
            k = (k < 255) ? k + 1 : 255;
            push(1'b0, 1'b0, 0);
            sb[sb.size() - 1] = '{bh: 1'b1, ph: 1'b0, kills: 8'(k)};
            fs();
            e = sb.pop_front();
            checks++;
            if ({bh_s, ph_s, kills_s} !== {e.bh, e.ph, e.kills}) begin
                failures++;
                $display("FAIL sat_kill_%0d: got bh=%b ph=%b kills=%0d expected bh=%b ph=%b kills=%0d",
                         i, bh_s, ph_s, kills_s, e.bh, e.ph, e.kills);
            end
            cyc();
            ticks(3);
        end
        checks++;
        if ({boom_s, revive_s, kills_s} !== {2'b00, 8'd255}) begin
            failures++;
            $display("FAIL sat_final: got boom/revive=%b kills=%0d expected 00 kills=255",
                     {boom_s, revive_s}, kills_s);
        end
    endtask

    initial begin
        test_reset();
        test_threshold();
        test_bullet_kill();
        test_both();
        test_no_exist();
        test_reset_mid();
        test_pulse_total();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/enemy_hit_judge.md
# enemy_hit_judge

Collision arbiter that sits directly upstream of the enemy plane judge. It watches the per-pixel enables of the enemy, the player bullet and the player plane during the VGA scan and counts overlapping pixels per frame. At the frame boundary it decides whether a hit occurred, then sequences the enemy's `boom` and `revive` inputs with the tick counts the enemy's explosion counter expects. It also emits one-cycle pulses to clear the bullet and to damage the player.

## Interface
Parameters:
- `HIT_MIN_PIXELS`, 4: overlap pixels per frame needed to declare a hit (debounce against single-pixel grazes).
- `BOOM_TICKS`, 255: number of `clk_move` rising edges `boom` is held high; 8-bit range 1..255.
- `REVIVE_TICKS`, 2: number of `clk_move` rising edges `revive` is held high; range 2..15.

Ports:
- `clk` input 1: system/pixel clock; all logic on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `clk_move` input 1: slow movement clock, synchronous to `clk`; rising edge detected internally.
- `frame_start` input 1: one-`clk` pulse at the first pixel of each frame.
- `enemy_en` input 1: enemy pixel opaque at the current scan position.
- `bullet_en` input 1: bullet pixel opaque at the current scan position.
- `player_en` input 1: player pixel opaque at the current scan position.
- `enemyplane_exist` input 1: enemy alive flag returned from the enemy stage.
- `boom` output 1: explosion request to the enemy stage (level).
- `revive` output 1: respawn request to the enemy stage (level).
- `bullet_hit` output 1: one-`clk` pulse; bullet consumed.
- `player_hit` output 1: one-`clk` pulse; player collided with the enemy.
- `kills` output 8: bullet kills since reset, saturates at 255.

## Operation
- Tick detect: `clk_move_d` is registered. `move_tick = clk_move & ~clk_move_d`.
- Overlap counters: `bcnt` counts `bullet_en & enemy_en`; `pcnt` counts `player_en & enemy_en`. Both are 12-bit and saturate at 4095.
  - Counting happens in IDLE only; in all other states both counters are held at 0.
  - On `frame_start`, each counter loads 1 if its overlap term is true that cycle, else 0. The frame_start pixel belongs to the new frame.
- State machine, states IDLE, BOOM, REVIVE; reset state IDLE.
- IDLE:
  - On `frame_start`, evaluate the previous frame using the counter values before the load.
  - If `bcnt >= HIT_MIN_PIXELS` and `enemyplane_exist`: pulse `bullet_hit`, increment `kills` (saturating), go to BOOM.
  - If `pcnt >= HIT_MIN_PIXELS` and `enemyplane_exist`: pulse `player_hit`, go to BOOM.
  - If both conditions hold, both pulses fire in the same cycle, `kills` increments once, and the state goes to BOOM.
  - If `enemyplane_exist` is 0, no hit is declared.
- BOOM:
  - `boom`=1; tick counter `tcnt` (8-bit) is cleared on entry.
  - Each `move_tick` increments `tcnt`.
  - When `move_tick` occurs with `tcnt == BOOM_TICKS-1`: clear `tcnt`, go to REVIVE.
- REVIVE:
  - `boom`=0, `revive`=1.
  - When `move_tick` occurs with `tcnt == REVIVE_TICKS-1`: go to IDLE.
  - With `REVIVE_TICKS >= 2`, the enemy's explosion counter clears on the first tick and the respawn is taken on a later tick.
- `frame_start` in BOOM/REVIVE is ignored apart from the counter load, which is still forced to 0.
- `boom` and `revive` are never 1 together.

## Timing
- Reset values: `boom`=0, `revive`=0, `bullet_hit`=0, `player_hit`=0, `kills`=0, state IDLE, `bcnt`=`pcnt`=`tcnt`=0, `clk_move_d`=0.
- All outputs are registered.
- `bullet_hit`/`player_hit` go high the `clk` after the deciding `frame_start` and stay high exactly one cycle.
- `boom` rises in that same cycle.
- `boom` falls and `revive` rises in the `clk` after the BOOM_TICKS-th `move_tick`.
- `revive` falls in the `clk` after the REVIVE_TICKS-th `move_tick`.
- A `move_tick` coinciding with the `frame_start` that causes entry to BOOM is not counted.
- `rst_n` low mid-sequence: all outputs drop asynchronously. After release the block resumes in IDLE and needs a fresh full frame before any hit.
- `clk_move` held high across reset does not produce a tick on release.

## Test plan
- 3 bullet/enemy overlap pixels in a frame, then `frame_start` → no `bullet_hit`, `boom` stays 0, `kills`=0.
- 4 overlap pixels, `enemyplane_exist`=1, then `frame_start` → `bullet_hit` high exactly 1 cycle, `boom`=1 next cycle, `kills`=1. After 255 `move_tick`s: `boom`=0, `revive`=1. After 2 more ticks: `revive`=0, state IDLE.
- Bullet and player overlaps both ≥4 in the same frame → `bullet_hit` and `player_hit` pulse in the same cycle, `kills` increments by 1, single BOOM sequence.
- 10 overlap pixels with `enemyplane_exist`=0 → no pulses, `boom` stays 0. Overlap pixels during BOOM → `bcnt` stays 0, no second hit.
- `rst_n` asserted at tick 100 of BOOM → `boom`=0 immediately. After release: IDLE, `kills`=0, and a hit is only declared after a full new frame.
- 256 kill sequences with BOOM_TICKS=1 → `kills` saturates at 255.
